fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Program-counter and IF/ID pipeline-register stage of the MIPS CPU. It drives the byte-address PC into the instruction memory and captures the returned word together with PC+4 for decode. It handles stall, branch/jump redirect, halt (exit syscall) and address-fault detection. The instruction memory is combinational, so one instruction is fetched per cycle.

Parameters:
RESET_PC, 32'h00400000, byte address of the first instruction. This is the text-segment base, word index 0x00100000.
MEM_WORDS, 257, number of instruction words mapped from RESET_PC. The last valid byte address is RESET_PC + 4*(MEM_WORDS-1) = 0x00400400.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-high reset
stall  input  1  hazard unit: hold PC and IF/ID
redirect_valid  input  1  taken branch/jump/jr resolved in decode
redirect_pc  input  32  byte address of the redirect target
halt  input  1  exit syscall decoded; stop fetching
instr_in  input  32  word returned by instruction memory for curr_pc
curr_pc  output  32  byte address presented to instruction memory
if_id_instr  output  32  latched instruction (0 = NOP when bubble)
if_id_pc4  output  32  latched curr_pc+4
if_id_valid  output  1  IF/ID holds a real instruction
fetch_count  output  32  count of instructions latched into IF/ID
halted  output  1  state == HALTED
pc_fault  output  1  state == FAULT (sticky)

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - curr_pc = RESET_PC; if_id_instr = 0; if_id_pc4 = 0; if_id_valid = 0; fetch_count = 0; halted = 0; pc_fault = 0; state = RUN.
- States are RUN, HALTED and FAULT. halted and pc_fault are decoded from the state and are never both 1.
- in_range(a) is true when a[1:0] == 0 and RESET_PC <= a <= RESET_PC + 4*(MEM_WORDS-1), using unsigned 32-bit compare.
- RUN: per edge, the first matching rule applies.
  1. halt=1 → HALTED. curr_pc holds. IF/ID becomes a bubble (instr 0, pc4 0, valid 0).
  2. redirect_valid=1 → curr_pc <= redirect_pc; IF/ID becomes a bubble. This overrides stall, because the wrong-path fetch is discarded. No range check is made here; the target is checked on the following cycle when it is fetched.
  3. stall=1 → curr_pc and all IF/ID fields hold. fetch_count holds.
  4. !in_range(curr_pc) → FAULT. curr_pc holds. IF/ID becomes a bubble.
  5. Otherwise → if_id_instr <= instr_in; if_id_pc4 <= curr_pc+4; if_id_valid <= 1; curr_pc <= curr_pc+4; fetch_count <= fetch_count+1.
- HALTED and FAULT are terminal until reset:
  - All inputs are ignored. curr_pc is frozen, IF/ID holds a bubble and fetch_count is frozen.
- Arithmetic:
  - PC+4 is 32-bit modulo. Wrap past 0xFFFFFFFC is caught by the range check on the next fetch.
  - fetch_count wraps from 0xFFFFFFFF to 0.
- Latency: one cycle from curr_pc to if_id_instr. A redirect produces exactly one bubble in IF/ID.
- Sequential run-off: after the last word (0x00400400) is latched, curr_pc = 0x00400404. The next unstalled, unredirected edge enters FAULT.
- Reset asserted mid-operation, including in HALTED or FAULT, returns every output to its reset value asynchronously. The first fetch after deassertion is RESET_PC.
- No combinational path exists from any input to any output.

Test Plan:
- Reset, then 3 edges with instr_in = 0x20080005, 0x20090007, 0x01095020 → if_id_instr follows each one cycle late; if_id_pc4 = 0x00400004, 0x00400008, 0x0040000C; curr_pc = 0x0040000C; fetch_count = 3.
- stall=1 for 2 edges at curr_pc 0x00400008 → curr_pc, if_id_instr, if_id_pc4 and fetch_count unchanged; advance resumes on the first edge after stall drops.
- redirect_valid=1 with redirect_pc = 0x00400040 and stall=1 in the same cycle → curr_pc = 0x00400040; if_id_valid = 0; if_id_instr = 0; next edge latches the word at 0x00400040 with if_id_pc4 = 0x00400044.
- Faults:
  - redirect_pc = 0x00400042 → one cycle later pc_fault = 1, curr_pc = 0x00400042, if_id_valid = 0; pc_fault stays 1 under further stimulus.
  - Sequential run to 0x00400404 → pc_fault = 1.
- halt=1 at fetch_count = 7 → halted = 1; curr_pc frozen; fetch_count stays 7; redirect_valid afterwards has no effect.
- Assert reset asynchronously mid-cycle while in FAULT → all outputs return to reset values before the next edge; fetch resumes from 0x00400000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, instruction-memory and IF/ID bundle
interface fetch_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr_in;
    logic [31:0] curr_pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [31:0] fetch_count;
    logic        halted;
    logic        pc_fault;

    modport slave (
        input  stall, redirect_valid, redirect_pc, halt, instr_in,
        output curr_pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, halted, pc_fault
    );

    modport master (
        output stall, redirect_valid, redirect_pc, halt, instr_in,
        input  curr_pc, if_id_instr, if_id_pc4, if_id_valid, fetch_count, halted, pc_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter and IF/ID pipeline register with halt and fault states
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h00400000,
    parameter int          MEM_WORDS = 257
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    localparam logic [31:0] LAST_PC = RESET_PC + 32'(4 * (MEM_WORDS - 1));

    typedef enum logic [1:0] {ST_RUN, ST_HALTED, ST_FAULT} state_t;

    state_t      state, state_n;
    logic [31:0] pc_q, pc_n;
    logic [31:0] instr_q, instr_n;
    logic [31:0] pc4_q, pc4_n;
    logic        valid_q, valid_n;
    logic [31:0] count_q, count_n;
    logic [31:0] pc_plus4;
    logic        pc_ok;

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_ok    = (pc_q[1:0] == 2'b00) && (pc_q >= RESET_PC) && (pc_q <= LAST_PC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RUN;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            count_q <= 32'd0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            instr_q <= instr_n;
            pc4_q   <= pc4_n;
            valid_q <= valid_n;
            count_q <= count_n;
        end
    end

    // Priority in RUN: halt, redirect (beats stall), stall, fault, fetch.
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        instr_n = instr_q;
        pc4_n   = pc4_q;
        valid_n = valid_q;
        count_n = count_q;
        case (state)
            ST_RUN: begin
                if (bus.halt) begin
                    state_n = ST_HALTED;
                    instr_n = 32'd0;
                    pc4_n   = 32'd0;
                    valid_n = 1'b0;
                end else if (bus.redirect_valid) begin
                    pc_n    = bus.redirect_pc;
                    instr_n = 32'd0;
                    pc4_n   = 32'd0;
                    valid_n = 1'b0;
                end else if (bus.stall) begin
                    pc_n = pc_q;
                end else if (!pc_ok) begin
                    state_n = ST_FAULT;
                    instr_n = 32'd0;
                    pc4_n   = 32'd0;
                    valid_n = 1'b0;
                end else begin
                    instr_n = bus.instr_in;
                    pc4_n   = pc_plus4;
                    valid_n = 1'b1;
                    pc_n    = pc_plus4;
                    count_n = count_q + 32'd1;
                end
            end
            default: begin
                state_n = state;
            end
        endcase
    end

    assign bus.curr_pc     = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc4   = pc4_q;
    assign bus.if_id_valid = valid_q;
    assign bus.fetch_count = count_q;
    assign bus.halted      = (state == ST_HALTED);
    assign bus.pc_fault    = (state == ST_FAULT);
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage with directed vectors
module tb_fetch_stage;
    logic clk;
    logic reset;

    fetch_stage_if bus ();

    fetch_stage #(
        .RESET_PC (32'h00400000),
        .MEM_WORDS(257)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [31:0] cnt;
        logic [1:0]  st;
    } exp_t;

    localparam logic [1:0] RUN = 2'd0, HLT = 2'd1, FLT = 2'd2;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, ".curr_pc"},     bus.curr_pc,             e.pc);
        chk({tag, ".if_id_instr"}, bus.if_id_instr,         e.instr);
        chk({tag, ".if_id_pc4"},   bus.if_id_pc4,           e.pc4);
        chk({tag, ".if_id_valid"}, {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        chk({tag, ".fetch_count"}, bus.fetch_count,         e.cnt);
        chk({tag, ".halted"},      {31'd0, bus.halted},     {31'd0, e.st == HLT});
        chk({tag, ".pc_fault"},    {31'd0, bus.pc_fault},   {31'd0, e.st == FLT});
    endtask

    task automatic check_reset_state(input string tag);
        exp_t e;
        e = '{pc: 32'h00400000, instr: 32'd0, pc4: 32'd0, valid: 1'b0, cnt: 32'd0, st: RUN};
        compare_all(tag, e);
    endtask

    // Monitor: every edge with a pending expectation is checked 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compare_all("edge", e);
        end
    end

    // Called at a negedge: drive inputs, queue the state expected after the next posedge.
    task automatic step(input logic s, input logic rv, input logic [31:0] rpc, input logic h,
                        input logic [31:0] ins,
                        input logic [31:0] e_pc, input logic [31:0] e_instr, input logic [31:0] e_pc4,
                        input logic e_valid, input logic [31:0] e_cnt, input logic [1:0] e_st);
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.halt           = h;
        bus.instr_in       = ins;
        sb.push_back('{pc: e_pc, instr: e_instr, pc4: e_pc4, valid: e_valid, cnt: e_cnt, st: e_st});
        @(negedge clk);
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        #1;
        check_reset_state("sync_reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        bus.halt           = 1'b0;
        bus.instr_in       = 32'd0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        //    stall rv  rpc           halt instr_in       curr_pc        if_id_instr    if_id_pc4      v     cnt  state
        step(0, 0, 32'h0,        0, 32'h20080005, 32'h00400004, 32'h20080005, 32'h00400004, 1, 32'd1, RUN);
        step(0, 0, 32'h0,        0, 32'h20090007, 32'h00400008, 32'h20090007, 32'h00400008, 1, 32'd2, RUN);
        step(1, 0, 32'h0,        0, 32'hAAAAAAAA, 32'h00400008, 32'h20090007, 32'h00400008, 1, 32'd2, RUN);
        step(1, 0, 32'h0,        0, 32'hBBBBBBBB, 32'h00400008, 32'h20090007, 32'h00400008, 1, 32'd2, RUN);
        step(0, 0, 32'h0,        0, 32'h01095020, 32'h0040000C, 32'h01095020, 32'h0040000C, 1, 32'd3, RUN);
        // redirect overrides a simultaneous stall and leaves one bubble
        step(1, 1, 32'h00400040, 0, 32'hDEADBEEF, 32'h00400040, 32'h0,        32'h0,        0, 32'd3, RUN);
        step(0, 0, 32'h0,        0, 32'h8C020000, 32'h00400044, 32'h8C020000, 32'h00400044, 1, 32'd4, RUN);
        step(0, 0, 32'h0,        0, 32'h00000001, 32'h00400048, 32'h00000001, 32'h00400048, 1, 32'd5, RUN);
        step(0, 0, 32'h0,        0, 32'h00000002, 32'h0040004C, 32'h00000002, 32'h0040004C, 1, 32'd6, RUN);
        step(0, 0, 32'h0,        0, 32'h00000003, 32'h00400050, 32'h00000003, 32'h00400050, 1, 32'd7, RUN);
        step(0, 0, 32'h0,        1, 32'h0000000C, 32'h00400050, 32'h0,        32'h0,        0, 32'd7, HLT);
        step(0, 1, 32'h00400000, 0, 32'h11111111, 32'h00400050, 32'h0,        32'h0,        0, 32'd7, HLT);
        step(0, 0, 32'h0,        0, 32'h22222222, 32'h00400050, 32'h0,        32'h0,        0, 32'd7, HLT);

        sync_reset();
        step(0, 0, 32'h0,        0, 32'h11111111, 32'h00400004, 32'h11111111, 32'h00400004, 1, 32'd1, RUN);
        step(0, 1, 32'h00400042, 0, 32'h33333333, 32'h00400042, 32'h0,        32'h0,        0, 32'd1, RUN);
        step(0, 0, 32'h0,        0, 32'h44444444, 32'h00400042, 32'h0,        32'h0,        0, 32'd1, FLT);
        step(0, 1, 32'h00400000, 0, 32'h55555555, 32'h00400042, 32'h0,        32'h0,        0, 32'd1, FLT);
        step(0, 0, 32'h0,        1, 32'h66666666, 32'h00400042, 32'h0,        32'h0,        0, 32'd1, FLT);

        // asynchronous reset while faulted, checked before the next rising edge
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_reset_state("async_reset");
        @(negedge clk);
        reset = 1'b0;

        step(0, 0, 32'h0,        0, 32'h24020001, 32'h00400004, 32'h24020001, 32'h00400004, 1, 32'd1, RUN);
        step(0, 1, 32'h00400400, 0, 32'h77777777, 32'h00400400, 32'h0,        32'h0,        0, 32'd1, RUN);
        step(0, 0, 32'h0,        0, 32'h0000ABCD, 32'h00400404, 32'h0000ABCD, 32'h00400404, 1, 32'd2, RUN);
        step(0, 0, 32'h0,        0, 32'h12345678, 32'h00400404, 32'h0,        32'h0,        0, 32'd2, FLT);

        sync_reset();
        step(0, 1, 32'h003FFFFC, 0, 32'h88888888, 32'h003FFFFC, 32'h0,        32'h0,        0, 32'd0, RUN);
        step(0, 0, 32'h0,        0, 32'h99999999, 32'h003FFFFC, 32'h0,        32'h0,        0, 32'd0, FLT);

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
